// File: rtl/ifetch_pkg.sv
// Shared fetch/decode constants: widths, PC step, canonical NOP and
// base RV32I opcode values used by the decode stage.
package ifetch_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int INSTR_W      = 32;
    localparam int PC_STEP      = 4;

    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] OPC_L = 7'b0000011;
    localparam logic [6:0] OPC_S = 7'b0100011;
    localparam logic [6:0] OPC_B = 7'b1100011;

    function automatic logic [6:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bundle: instruction-memory read port, branch redirect
// and the valid/ready handshake towards decode.
interface ifetch_if
    import ifetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) ();

    logic               imem_req;
    logic [XLEN-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect;
    logic [XLEN-1:0]    redirect_pc;
    logic               if_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [XLEN-1:0]    if_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  redirect,
        input  redirect_pc,
        output if_valid,
        input  id_ready,
        output if_instr,
        output if_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output redirect,
        output redirect_pc,
        input  if_valid,
        output id_ready,
        input  if_instr,
        input  if_pc
    );

endinterface

// File: rtl/ifetch_fifo.sv
// fetch_fifo: small synchronous FIFO of {pc, instr} records.
// Clear dominates push; push while full is accepted only with a pop.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Pointer and occupancy update, clear wins over everything.
    always_comb begin
        do_pop   = pop && (cnt_q != '0);
        do_push  = push && ((cnt_q != DEPTH_C) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer/count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage write; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == DEPTH_C);
    assign count = cnt_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, one-deep imem read pipeline, fetch buffer.
// Optional macro IFETCH_PERF_EN adds saturating pop/stall counters.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_if.master      bus
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_stalls
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = XLEN + INSTR_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ret_pc_q, ret_pc_d;
    logic            inflight_q, inflight_d;

    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [DW-1:0]   fifo_dout;
    logic [CW-1:0]   used;
    logic [XLEN-1:0] pc_tgt;
    logic            pop, kill, push, issue;

    // Issue credit counts buffered plus in-flight words, minus the one leaving now.
    always_comb begin
        pop    = !fifo_empty && bus.id_ready;
        kill   = bus.redirect && inflight_q;
        push   = inflight_q && !kill;
        used   = fifo_count + CW'(inflight_q) - CW'(pop);
        issue  = !rst && !bus.redirect
                 && (!fifo_full || pop) && (used < DEPTH_C);
        pc_tgt = bus.redirect_pc & ~XLEN'(3);
    end

    // PC and in-flight tracking; redirect overrides issue.
    always_comb begin
        pc_d       = pc_q;
        ret_pc_d   = ret_pc_q;
        inflight_d = 1'b0;
        if (bus.redirect) begin
            pc_d = pc_tgt;
        end else if (issue) begin
            pc_d       = pc_q + XLEN'(PC_STEP);
            ret_pc_d   = pc_q;
            inflight_d = 1'b1;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            ret_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ret_pc_q   <= ret_pc_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (bus.redirect),
        .din   ({ret_pc_q, bus.imem_rdata}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = !fifo_empty;
    assign bus.if_instr  = fifo_empty ? '0 : fifo_dout[INSTR_W-1:0];
    assign bus.if_pc     = fifo_empty ? '0 : fifo_dout[DW-1:INSTR_W];

`ifdef IFETCH_PERF_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] stalls_q, stalls_d;

    // Saturating delivered/stalled counters.
    always_comb begin
        fetched_d = fetched_q;
        stalls_d  = stalls_q;
        if (pop && (fetched_q != '1))
            fetched_d = fetched_q + 32'd1;
        if (!fifo_empty && !bus.id_ready && (stalls_q != '1))
            stalls_d = stalls_q + 32'd1;
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetched_q <= '0;
            stalls_q  <= '0;
        end else begin
            fetched_q <= fetched_d;
            stalls_q  <= stalls_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed cycle table, wrap/perf sequences,
// then random traffic against a queue-based delivery model.
`timescale 1ns/1ps
module tb_ifetch_unit;
    import ifetch_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifetch_if #(.XLEN(32)) bus ();
    ifetch_if #(.XLEN(32)) wbus ();

`ifdef IFETCH_PERF_EN
    logic [31:0] pf_f, pf_s, wpf_f, wpf_s;
`endif

    ifetch_unit #(
        .XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
`ifdef IFETCH_PERF_EN
        , .perf_fetched(pf_f), .perf_stalls(pf_s)
`endif
    );

    ifetch_unit #(
        .XLEN(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)
    ) u_wrap (
        .clk(clk), .rst(rst), .bus(wbus)
`ifdef IFETCH_PERF_EN
        , .perf_fetched(wpf_f), .perf_stalls(wpf_s)
`endif
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'h0050_0093 + (a >> 2) * 32'h0050_0080;
    endfunction

    // Instruction memory: data valid the cycle after a request.
    logic        m_req = 1'b0, w_req = 1'b0;
    logic [31:0] m_addr = '0, w_addr = '0;
    always @(posedge clk) begin
        m_req  = bus.imem_req;
        m_addr = bus.imem_addr;
        w_req  = wbus.imem_req;
        w_addr = wbus.imem_addr;
    end
    always @(negedge clk) begin
        bus.imem_rdata  = m_req ? instr_of(m_addr) : 32'hDEAD_BEEF;
        wbus.imem_rdata = w_req ? instr_of(w_addr) : 32'hDEAD_BEEF;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic y,
                                input logic d, input logic [31:0] rp,
                                input logic q, input logic [31:0] a,
                                input logic v, input logic [31:0] p);
        vec_t e;
        e.rst = r; e.rdy = y; e.redir = d; e.rpc = rp;
        e.req = q; e.addr = a; e.vld = v; e.pc = p;
        return e;
    endfunction

    typedef struct {
        logic [31:0] pc;
        int          t;
    } ent_t;

    task automatic drive(input logic r, input logic y,
                         input logic d, input logic [31:0] rp);
        @(negedge clk);
        rst = r;
        bus.id_ready = y;
        bus.redirect = d;
        bus.redirect_pc = rp;
        #1;
    endtask

    vec_t vecs[$];
    ent_t mq[$];

    initial begin
        bus.id_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        wbus.id_ready = 1'b1;
        wbus.redirect = 1'b0;
        wbus.redirect_pc = '0;
        repeat (3) @(negedge clk);

        // release with decode always ready: PCs 0,4,8 back to back
        vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h0,   0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h4,   0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h8,   1, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'hC,   1, 32'h4));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h10,  1, 32'h8));
        // reset mid-stream takes effect immediately
        vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,   0, 0));
        // backpressure: head held, requests stop once full
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h0,   0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h4,   0, 0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 32'h8, 1, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h8,   1, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'hC,   1, 32'h4));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h10,  1, 32'h8));
        // redirect while the read to 0x8 is in flight
        vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h0,   0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h4,   0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h8,   1, 32'h0));
        vecs.push_back(mk(0, 1, 1, 32'h100, 0, 32'hC, 1, 32'h4));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h100, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h104, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h108, 1, 32'h100));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h10C, 1, 32'h104));
        // misaligned target is forced to a word boundary
        vecs.push_back(mk(0, 1, 1, 32'h103, 0, 32'h110, 1, 32'h108));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h100, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h104, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h108, 1, 32'h100));
        // back-to-back redirects: the last one wins
        vecs.push_back(mk(0, 1, 1, 32'h200, 0, 32'h10C, 1, 32'h104));
        vecs.push_back(mk(0, 1, 1, 32'h300, 0, 32'h200, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h300, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h304, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h308, 1, 32'h300));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
            chk($sformatf("v%0d_req", i), 32'(bus.imem_req), 32'(vecs[i].req));
            chk($sformatf("v%0d_addr", i), bus.imem_addr, vecs[i].addr);
            chk($sformatf("v%0d_valid", i), 32'(bus.if_valid), 32'(vecs[i].vld));
            chk($sformatf("v%0d_pc", i), bus.if_pc, vecs[i].pc);
            chk($sformatf("v%0d_instr", i), bus.if_instr,
                vecs[i].vld ? instr_of(vecs[i].pc) : 32'h0);
        end

        // PC wrap from the top of the address space
        drive(1, 1, 0, 0);
        drive(0, 1, 0, 0);
        chk("wrap_addr0", wbus.imem_addr, 32'hFFFF_FFFC);
        drive(0, 1, 0, 0);
        chk("wrap_addr1", wbus.imem_addr, 32'h0);
        drive(0, 1, 0, 0);
        chk("wrap_pc0", wbus.if_pc, 32'hFFFF_FFFC);
        chk("wrap_instr0", wbus.if_instr, instr_of(32'hFFFF_FFFC));
        drive(0, 1, 0, 0);
        chk("wrap_pc1", wbus.if_pc, 32'h0);
        chk("wrap_instr1", wbus.if_instr, instr_of(32'h0));

        // 10 pops with 3 stall cycles, then reset mid-stream
        drive(1, 1, 0, 0);
        for (int r = 0; r < 15; r++) begin
            drive(0, !(r >= 5 && r <= 7), 0, 0);
            if (r >= 2)
                chk($sformatf("pf_valid%0d", r), 32'(bus.if_valid), 32'h1);
        end
        drive(0, 0, 0, 0);
`ifdef IFETCH_PERF_EN
        chk("perf_fetched", pf_f, 32'd10);
        chk("perf_stalls", pf_s, 32'd3);
`endif
        drive(1, 0, 0, 0);
        chk("mid_rst_valid", 32'(bus.if_valid), 32'h0);
        chk("mid_rst_req", 32'(bus.imem_req), 32'h0);
        chk("mid_rst_pc", bus.if_pc, 32'h0);
        chk("mid_rst_instr", bus.if_instr, 32'h0);
`ifdef IFETCH_PERF_EN
        chk("mid_rst_pf", pf_f, 32'h0);
        chk("mid_rst_ps", pf_s, 32'h0);
`endif

        // random traffic against the delivery model
        begin
            logic [31:0] next_pc = 32'h0;
            int          now = 0;
            int          m_f = 0, m_s = 0;
            for (int n = 0; n < 3000; n++) begin
                logic        y, d, vis, pop, ereq;
                logic [31:0] rp;
                int          sz;
                y  = ($urandom_range(0, 3) != 0);
                d  = ($urandom_range(0, 19) == 0);
                rp = ($urandom_range(0, 3) == 0)
                     ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                     : $urandom;
                drive(0, y, d, rp);
                vis = (mq.size() > 0) && (mq[0].t <= now - 2);
                chk("rnd_valid", 32'(bus.if_valid), 32'(vis));
                if (vis) begin
                    chk("rnd_pc", bus.if_pc, mq[0].pc);
                    chk("rnd_instr", bus.if_instr, instr_of(mq[0].pc));
                end else begin
                    chk("rnd_pc_idle", bus.if_pc, 32'h0);
                    chk("rnd_instr_idle", bus.if_instr, 32'h0);
                end
                pop  = vis && y;
                sz   = mq.size() - (pop ? 1 : 0);
                ereq = !d && (sz < DEPTH);
                chk("rnd_req", 32'(bus.imem_req), 32'(ereq));
                if (ereq) chk("rnd_addr", bus.imem_addr, next_pc);
                if (pop) m_f++;
                if (vis && !y) m_s++;
                if (pop) void'(mq.pop_front());
                if (d) begin
                    mq.delete();
                    next_pc = rp & ~32'h3;
                end else if (ereq) begin
                    mq.push_back('{next_pc, now});
                    next_pc = next_pc + 32'd4;
                end
                now++;
            end
            drive(0, 0, 0, 0);
`ifdef IFETCH_PERF_EN
            chk("rnd_perf_fetched", pf_f, 32'(m_f));
            chk("rnd_perf_stalls", pf_s, 32'(m_s));
`else
            if (m_f == 0) chk("rnd_deliveries", 32'(m_f), 32'h1);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
